// File: rtl/mprj_io_cfg_stager.sv
// Shadow/active per-pad configuration bank for the user GPIO ring.
// Apply copies shadow to active one pad every STAGGER cycles.
module mprj_io_cfg_stager #(
    parameter int          NPADS       = 38,
    parameter int          STAGGER     = 4,
    parameter logic [11:0] DEFAULT_CFG = 12'h201
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [5:0]         wr_idx,
    input  logic [11:0]        wr_data,
    input  logic [5:0]         rd_idx,
    output logic [11:0]        rd_data,
    input  logic               apply_req,
    output logic               apply_ack,
    output logic               busy,
    output logic               done,
    output logic [NPADS-1:0]   mprj_io_oeb,
    output logic [NPADS-1:0]   mprj_io_holdover,
    output logic [NPADS-1:0]   mprj_io_inp_dis,
    output logic [NPADS-1:0]   mprj_io_ib_mode_sel,
    output logic [NPADS-1:0]   mprj_io_analog_en,
    output logic [NPADS-1:0]   mprj_io_analog_sel,
    output logic [NPADS-1:0]   mprj_io_analog_pol,
    output logic [NPADS-1:0]   mprj_io_slow_sel,
    output logic [NPADS-1:0]   mprj_io_vtrip_sel,
    output logic [NPADS*3-1:0] mprj_io_dm
);

    localparam int          GW         = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam logic [GW-1:0] GAP_RELOAD = GW'(STAGGER - 1);
    localparam logic [5:0]  NPADS_W    = 6'(NPADS);
    localparam logic [5:0]  LAST_IDX   = 6'(NPADS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     idx_q, idx_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           ack_q, ack_d;
    logic [11:0]    rd_data_q, rd_data_d;
    logic [11:0]    shadow_q [NPADS];
    logic [11:0]    shadow_d [NPADS];
    logic [11:0]    active_q [NPADS];
    logic [11:0]    active_d [NPADS];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        ack_d     = 1'b0;
        shadow_d  = shadow_q;
        active_d  = active_q;
        rd_data_d = 12'h000;

        if (rd_idx < NPADS_W) begin
            rd_data_d = active_q[rd_idx];
        end

        if (wr_en && (wr_idx < NPADS_W)) begin
            shadow_d[wr_idx] = wr_data;
        end

        // Copies read shadow_q, so a same-cycle write lands next pass.
        unique case (state_q)
            S_IDLE: begin
                if (apply_req) begin
                    ack_d   = 1'b1;
                    idx_d   = 6'd0;
                    gap_d   = '0;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                if (gap_q == '0) begin
                    active_d[idx_q] = shadow_q[idx_q];
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                        gap_d = GAP_RELOAD;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= 6'd0;
            gap_q     <= '0;
            ack_q     <= 1'b0;
            rd_data_q <= DEFAULT_CFG;
            shadow_q  <= '{default: DEFAULT_CFG};
            active_q  <= '{default: DEFAULT_CFG};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            ack_q     <= ack_d;
            rd_data_q <= rd_data_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign apply_ack = ack_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

    always_comb begin
        mprj_io_oeb         = '0;
        mprj_io_holdover    = '0;
        mprj_io_inp_dis     = '0;
        mprj_io_ib_mode_sel = '0;
        mprj_io_analog_en   = '0;
        mprj_io_analog_sel  = '0;
        mprj_io_analog_pol  = '0;
        mprj_io_slow_sel    = '0;
        mprj_io_vtrip_sel   = '0;
        mprj_io_dm          = '0;
        for (int i = 0; i < NPADS; i++) begin
            mprj_io_oeb[i]         = active_q[i][0];
            mprj_io_holdover[i]    = active_q[i][1];
            mprj_io_inp_dis[i]     = active_q[i][2];
            mprj_io_ib_mode_sel[i] = active_q[i][3];
            mprj_io_analog_en[i]   = active_q[i][4];
            mprj_io_analog_sel[i]  = active_q[i][5];
            mprj_io_analog_pol[i]  = active_q[i][6];
            mprj_io_slow_sel[i]    = active_q[i][7];
            mprj_io_vtrip_sel[i]   = active_q[i][8];
            mprj_io_dm[3*i +: 3]   = active_q[i][11:9];
        end
    end

endmodule
